// File: rtl/scoreboard_pkg.sv
// Shared types for the commit scoreboard: FSM states, error codes and the
// default commit record layout stored in the expected-commit FIFO.
package scoreboard_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_PASS,
    ST_FAIL
  } sb_state_t;

  typedef enum logic [2:0] {
    ERR_NONE,
    ERR_PC,
    ERR_INSTR,
    ERR_RD,
    ERR_DATA,
    ERR_UNDERFLOW,
    ERR_EXTRA,
    ERR_TIMEOUT
  } err_t;

  localparam int unsigned COMMIT_ADDR_W = 32;
  localparam int unsigned COMMIT_DATA_W = 32;
  localparam int unsigned INSTR_W       = 32;
  localparam int unsigned RD_W          = 5;

  typedef struct packed {
    logic [COMMIT_ADDR_W-1:0] pc;
    logic [INSTR_W-1:0]       instr;
    logic [RD_W-1:0]          rd;
    logic                     we;
    logic [COMMIT_DATA_W-1:0] data;
  } commit_t;

endpackage

// File: rtl/commit_fifo.sv
// Expected-commit FIFO: power-of-two depth, wrapping pointers and an extra
// count bit to tell full from empty. No push/pop bypass when full.
module commit_fifo
  import scoreboard_pkg::*;
#(
  parameter int unsigned DEPTH   = 8,
  parameter type         entry_t = commit_t
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   push_i,
  input  entry_t data_i,
  input  logic   pop_i,
  output entry_t head_o,
  output logic   full_o,
  output logic   empty_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  entry_t           mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [PTR_W:0]   count_q;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (count_q == (PTR_W+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign head_o  = mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (PTR_W+1)'(1);
        2'b01:   count_q <= count_q - (PTR_W+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage is left unreset; the count alone decides what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/commit_scoreboard.sv
// Commit checker: compares CPU commits against buffered golden-model commits,
// counts progress and errors, and drives the end-of-test drain handshake.
module commit_scoreboard
  import scoreboard_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH     = 32,
  parameter int unsigned           DATA_WIDTH     = 32,
  parameter int unsigned           DEPTH          = 8,
  parameter int unsigned           CNT_WIDTH      = 32,
  parameter int unsigned           TIMEOUT_CYCLES = 1024,
  parameter logic [ADDR_WIDTH-1:0] END_PC         = 88,
  parameter bit                    STOP_ON_ERROR  = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic                  exp_valid_i,
  output logic                  exp_ready_o,
  input  logic [ADDR_WIDTH-1:0] exp_pc_i,
  input  logic [31:0]           exp_instr_i,
  input  logic [4:0]            exp_rd_i,
  input  logic                  exp_we_i,
  input  logic [DATA_WIDTH-1:0] exp_data_i,
  input  logic                  dut_valid_i,
  input  logic [ADDR_WIDTH-1:0] dut_pc_i,
  input  logic [31:0]           dut_instr_i,
  input  logic [4:0]            dut_rd_i,
  input  logic                  dut_we_i,
  input  logic [DATA_WIDTH-1:0] dut_data_i,
  input  logic                  done_i,
  output logic                  finish_o,
  output logic                  mismatch_o,
  output logic [2:0]            err_code_o,
  output logic [CNT_WIDTH-1:0]  commit_cnt_o,
  output logic [CNT_WIDTH-1:0]  mismatch_cnt_o,
  output logic [CNT_WIDTH-1:0]  cycle_cnt_o,
  output logic [2:0]            state_o,
  output logic                  pass_o,
  output logic                  fail_o
);

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] pc;
    logic [31:0]           instr;
    logic [4:0]            rd;
    logic                  we;
    logic [DATA_WIDTH-1:0] data;
  } entry_t;

  localparam int unsigned     WD_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

  sb_state_t            state_q, state_d;
  logic [WD_W-1:0]      wd_q, wd_d;
  err_t                 err_code_q;
  logic                 mismatch_q;
  logic [CNT_WIDTH-1:0] commit_cnt_q, commit_cnt_d;
  logic [CNT_WIDTH-1:0] mismatch_cnt_q, mismatch_cnt_d;
  logic [CNT_WIDTH-1:0] cycle_cnt_q, cycle_cnt_d;

  entry_t exp_entry, head;
  logic   fifo_full, fifo_empty, push, pop;
  logic   commit_ev;
  err_t   cmp_err, err_now;

  assign exp_ready_o = rst && !fifo_full && (state_q == ST_IDLE || state_q == ST_RUN);
  assign push        = exp_valid_i && exp_ready_o;
  assign exp_entry   = '{pc: exp_pc_i, instr: exp_instr_i, rd: exp_rd_i,
                         we: exp_we_i, data: exp_data_i};

  commit_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .data_i  (exp_entry),
    .pop_i   (pop),
    .head_o  (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Data only matters when a register is really written (x0 writes are dropped).
  always_comb begin
    cmp_err = ERR_NONE;
    if (head.pc != dut_pc_i)                                   cmp_err = ERR_PC;
    else if (head.instr != dut_instr_i)                        cmp_err = ERR_INSTR;
    else if (head.we != dut_we_i || head.rd != dut_rd_i)       cmp_err = ERR_RD;
    else if (head.we && head.rd != '0 && head.data != dut_data_i) cmp_err = ERR_DATA;
  end

  always_comb begin
    state_d   = state_q;
    wd_d      = wd_q;
    err_now   = ERR_NONE;
    pop       = 1'b0;
    commit_ev = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        wd_d = '0;
        if (start_i) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (dut_valid_i) begin
          commit_ev = 1'b1;
          wd_d      = '0;
          if (fifo_empty) begin
            err_now = ERR_UNDERFLOW;
          end else begin
            pop     = 1'b1;
            err_now = cmp_err;
          end
          if (err_now != ERR_NONE) begin
            if (STOP_ON_ERROR) state_d = ST_FAIL;
          end else if (head.pc == END_PC) begin
            state_d = ST_DRAIN;
          end
        end else if (wd_q >= WD_LAST) begin
          err_now = ERR_TIMEOUT;
          state_d = ST_FAIL;
        end else begin
          wd_d = wd_q + WD_W'(1);
        end
      end
      // The watchdog here measures time since entering DRAIN, commits do not rearm it.
      ST_DRAIN: begin
        if (wd_q < WD_LAST) wd_d = wd_q + WD_W'(1);
        if (dut_valid_i)                    err_now = ERR_EXTRA;
        else if (!done_i && wd_q >= WD_LAST) err_now = ERR_TIMEOUT;
        if (done_i) begin
          state_d = (mismatch_cnt_q == '0 && err_now == ERR_NONE) ? ST_PASS : ST_FAIL;
        end else if (err_now == ERR_TIMEOUT || (err_now != ERR_NONE && STOP_ON_ERROR)) begin
          state_d = ST_FAIL;
        end
      end
      default: ;
    endcase
  end

  assign commit_cnt_d   = (commit_ev && commit_cnt_q != '1) ? commit_cnt_q + CNT_WIDTH'(1)
                                                            : commit_cnt_q;
  assign mismatch_cnt_d = (err_now != ERR_NONE && mismatch_cnt_q != '1)
                          ? mismatch_cnt_q + CNT_WIDTH'(1) : mismatch_cnt_q;
  assign cycle_cnt_d    = ((state_q == ST_RUN || state_q == ST_DRAIN) && cycle_cnt_q != '1)
                          ? cycle_cnt_q + CNT_WIDTH'(1) : cycle_cnt_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q        <= ST_IDLE;
      wd_q           <= '0;
      err_code_q     <= ERR_NONE;
      mismatch_q     <= 1'b0;
      commit_cnt_q   <= '0;
      mismatch_cnt_q <= '0;
      cycle_cnt_q    <= '0;
    end else begin
      state_q        <= state_d;
      wd_q           <= wd_d;
      mismatch_q     <= (err_now != ERR_NONE);
      if (err_now != ERR_NONE) err_code_q <= err_now;
      commit_cnt_q   <= commit_cnt_d;
      mismatch_cnt_q <= mismatch_cnt_d;
      cycle_cnt_q    <= cycle_cnt_d;
    end
  end

  assign finish_o       = (state_q == ST_DRAIN);
  assign pass_o         = (state_q == ST_PASS);
  assign fail_o         = (state_q == ST_FAIL);
  assign mismatch_o     = mismatch_q;
  assign err_code_o     = err_code_q;
  assign commit_cnt_o   = commit_cnt_q;
  assign mismatch_cnt_o = mismatch_cnt_q;
  assign cycle_cnt_o    = cycle_cnt_q;
  assign state_o        = state_q;

endmodule

// File: tb/tb_commit_scoreboard.sv
// Directed bench for commit_scoreboard: two instances share stimulus, one
// small/stop-on-error (A) and one continue-on-error (B).
module tb_commit_scoreboard;
  import scoreboard_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_i, exp_valid_i, exp_we_i, dut_valid_i, dut_we_i, done_i;
  logic [31:0] exp_pc_i, exp_instr_i, exp_data_i, dut_pc_i, dut_instr_i, dut_data_i;
  logic [4:0]  exp_rd_i, dut_rd_i;

  logic        readyA, finishA, mmA, passA, failA;
  logic [2:0]  errA, stA;
  logic [31:0] ccA, mcA, cycA;
  logic        readyB, finishB, mmB, passB, failB;
  logic [2:0]  errB, stB;
  logic [31:0] ccB, mcB, cycB;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  commit_scoreboard #(.DEPTH(4), .TIMEOUT_CYCLES(16), .END_PC(32'd88), .STOP_ON_ERROR(1'b1)) dutA (
    .clk(clk), .rst(rst), .start_i(start_i), .exp_valid_i(exp_valid_i), .exp_ready_o(readyA),
    .exp_pc_i(exp_pc_i), .exp_instr_i(exp_instr_i), .exp_rd_i(exp_rd_i), .exp_we_i(exp_we_i),
    .exp_data_i(exp_data_i), .dut_valid_i(dut_valid_i), .dut_pc_i(dut_pc_i),
    .dut_instr_i(dut_instr_i), .dut_rd_i(dut_rd_i), .dut_we_i(dut_we_i), .dut_data_i(dut_data_i),
    .done_i(done_i), .finish_o(finishA), .mismatch_o(mmA), .err_code_o(errA),
    .commit_cnt_o(ccA), .mismatch_cnt_o(mcA), .cycle_cnt_o(cycA), .state_o(stA),
    .pass_o(passA), .fail_o(failA));

  commit_scoreboard #(.DEPTH(8), .TIMEOUT_CYCLES(64), .END_PC(32'd88), .STOP_ON_ERROR(1'b0)) dutB (
    .clk(clk), .rst(rst), .start_i(start_i), .exp_valid_i(exp_valid_i), .exp_ready_o(readyB),
    .exp_pc_i(exp_pc_i), .exp_instr_i(exp_instr_i), .exp_rd_i(exp_rd_i), .exp_we_i(exp_we_i),
    .exp_data_i(exp_data_i), .dut_valid_i(dut_valid_i), .dut_pc_i(dut_pc_i),
    .dut_instr_i(dut_instr_i), .dut_rd_i(dut_rd_i), .dut_we_i(dut_we_i), .dut_data_i(dut_data_i),
    .done_i(done_i), .finish_o(finishB), .mismatch_o(mmB), .err_code_o(errB),
    .commit_cnt_o(ccB), .mismatch_cnt_o(mcB), .cycle_cnt_o(cycB), .state_o(stB),
    .pass_o(passB), .fail_o(failB));

  task tick();
    @(posedge clk);
    #1;
  endtask

  task doReset();
    start_i = 0; exp_valid_i = 0; dut_valid_i = 0; done_i = 0;
    exp_pc_i = 0; exp_instr_i = 0; exp_rd_i = 0; exp_we_i = 0; exp_data_i = 0;
    dut_pc_i = 0; dut_instr_i = 0; dut_rd_i = 0; dut_we_i = 0; dut_data_i = 0;
    rst = 0;
    tick();
    tick();
    rst = 1;
  endtask

  task startRun();
    start_i = 1;
    tick();
    start_i = 0;
  endtask

  task pushExp(input logic [31:0] pc, input logic [31:0] instr, input logic [4:0] rd,
               input logic we, input logic [31:0] data);
    exp_valid_i = 1; exp_pc_i = pc; exp_instr_i = instr; exp_rd_i = rd;
    exp_we_i = we; exp_data_i = data;
    tick();
    exp_valid_i = 0;
  endtask

  task dutCommit(input logic [31:0] pc, input logic [31:0] instr, input logic [4:0] rd,
                 input logic we, input logic [31:0] data);
    dut_valid_i = 1; dut_pc_i = pc; dut_instr_i = instr; dut_rd_i = rd;
    dut_we_i = we; dut_data_i = data;
    tick();
    dut_valid_i = 0;
  endtask

  task test_reset();
    doReset();
    rst = 0;
    tick();
    checks++; if (stA !== ST_IDLE) begin errors++; $display("[TB] FAIL reset_state got=%0d exp=%0d", stA, ST_IDLE); end
    checks++; if (readyA !== 1'b0) begin errors++; $display("[TB] FAIL reset_ready got=%0b exp=0", readyA); end
    checks++; if ({finishA, mmA, passA, failA} !== 4'b0) begin errors++; $display("[TB] FAIL reset_flags got=%b exp=0000", {finishA, mmA, passA, failA}); end
    checks++; if (errA !== ERR_NONE || ccA !== 0 || mcA !== 0 || cycA !== 0) begin errors++; $display("[TB] FAIL reset_counters got err=%0d cc=%0d mc=%0d cyc=%0d exp all 0", errA, ccA, mcA, cycA); end
    rst = 1;
    tick();
    checks++; if (readyA !== 1'b1) begin errors++; $display("[TB] FAIL idle_ready got=%0b exp=1", readyA); end
  endtask

  task test_match();
    logic saw;
    saw = 0;
    doReset();
    for (int i = 0; i < 3; i++) pushExp(32'h1000 + 4*i, 32'h0050_0093 + i, 5'd1 + 5'(i), 1'b1, 32'h5 + i);
    startRun();
    checks++; if (stA !== ST_RUN) begin errors++; $display("[TB] FAIL t1_state_run got=%0d exp=%0d", stA, ST_RUN); end
    for (int i = 0; i < 3; i++) begin
      dutCommit(32'h1000 + 4*i, 32'h0050_0093 + i, 5'd1 + 5'(i), 1'b1, 32'h5 + i);
      if (mmA) saw = 1;
    end
    checks++; if (saw !== 1'b0) begin errors++; $display("[TB] FAIL t1_no_mismatch got=%0b exp=0", saw); end
    checks++; if (ccA !== 32'd3) begin errors++; $display("[TB] FAIL t1_commit_cnt got=%0d exp=3", ccA); end
    checks++; if (mcA !== 32'd0) begin errors++; $display("[TB] FAIL t1_mismatch_cnt got=%0d exp=0", mcA); end
  endtask

  task test_data_error();
    doReset();
    pushExp(32'h2000, 32'h0050_0093, 5'd1, 1'b1, 32'h5);
    startRun();
    dutCommit(32'h2000, 32'h0050_0093, 5'd1, 1'b1, 32'h6);
    checks++; if (mmA !== 1'b1) begin errors++; $display("[TB] FAIL t2_pulse got=%0b exp=1", mmA); end
    checks++; if (errA !== ERR_DATA) begin errors++; $display("[TB] FAIL t2_err_code got=%0d exp=%0d", errA, ERR_DATA); end
    checks++; if (stA !== ST_FAIL || failA !== 1'b1) begin errors++; $display("[TB] FAIL t2_verdict got state=%0d fail=%0b exp state=%0d fail=1", stA, failA, ST_FAIL); end
    tick();
    checks++; if (mmA !== 1'b0 || errA !== ERR_DATA) begin errors++; $display("[TB] FAIL t2_pulse_end got mm=%0b err=%0d exp mm=0 err=%0d", mmA, errA, ERR_DATA); end
  endtask

  task test_fifo_full();
    logic saw;
    saw = 0;
    doReset();
    for (int i = 0; i < 4; i++) pushExp(32'h10 + 4*i, 32'h100 + i, 5'd2, 1'b1, 32'h40 + i);
    checks++; if (readyA !== 1'b0) begin errors++; $display("[TB] FAIL t3_full_ready got=%0b exp=0", readyA); end
    pushExp(32'h20, 32'h104, 5'd2, 1'b1, 32'h44);
    startRun();
    dut_valid_i = 1; dut_pc_i = 32'h10; dut_instr_i = 32'h100; dut_rd_i = 5'd2;
    dut_we_i = 1; dut_data_i = 32'h40;
    exp_valid_i = 1; exp_pc_i = 32'h99; exp_instr_i = 32'h0; exp_rd_i = 0; exp_we_i = 0; exp_data_i = 0;
    #2;
    checks++; if (readyA !== 1'b0) begin errors++; $display("[TB] FAIL t3_no_bypass got=%0b exp=0", readyA); end
    tick();
    dut_valid_i = 0; exp_valid_i = 0;
    if (mmA) saw = 1;
    checks++; if (readyA !== 1'b1) begin errors++; $display("[TB] FAIL t3_ready_after_pop got=%0b exp=1", readyA); end
    pushExp(32'h20, 32'h104, 5'd2, 1'b1, 32'h44);
    for (int i = 1; i < 5; i++) begin
      dutCommit(32'h10 + 4*i, 32'h100 + i, 5'd2, 1'b1, 32'h40 + i);
      if (mmA) saw = 1;
    end
    checks++; if (saw !== 1'b0 || stA !== ST_RUN) begin errors++; $display("[TB] FAIL t3_order got mism=%0b state=%0d exp mism=0 state=%0d", saw, stA, ST_RUN); end
    checks++; if (ccA !== 32'd5 || mcA !== 32'd0) begin errors++; $display("[TB] FAIL t3_counts got cc=%0d mc=%0d exp cc=5 mc=0", ccA, mcA); end
  endtask

  task test_underflow();
    doReset();
    startRun();
    dutCommit(32'h3000, 32'h13, 5'd3, 1'b1, 32'h1);
    checks++; if (mmB !== 1'b1 || errB !== ERR_UNDERFLOW) begin errors++; $display("[TB] FAIL t4_underflow got mm=%0b err=%0d exp mm=1 err=%0d", mmB, errB, ERR_UNDERFLOW); end
    checks++; if (ccB !== 32'd1 || mcB !== 32'd1 || stB !== ST_RUN) begin errors++; $display("[TB] FAIL t4_continue got cc=%0d mc=%0d st=%0d exp cc=1 mc=1 st=%0d", ccB, mcB, stB, ST_RUN); end
    pushExp(32'h3004, 32'h0110_0013, 5'd0, 1'b1, 32'h11);
    dutCommit(32'h3004, 32'h0110_0013, 5'd0, 1'b1, 32'h22);
    checks++; if (mmB !== 1'b0 || mcB !== 32'd1 || ccB !== 32'd2) begin errors++; $display("[TB] FAIL t4_rd0 got mm=%0b mc=%0d cc=%0d exp mm=0 mc=1 cc=2", mmB, mcB, ccB); end
  endtask

  task test_end_pass();
    doReset();
    pushExp(32'h54, 32'h33, 5'd4, 1'b1, 32'h1);
    pushExp(32'd88, 32'h6f, 5'd0, 1'b0, 32'h0);
    startRun();
    dutCommit(32'h54, 32'h33, 5'd4, 1'b1, 32'h1);
    checks++; if (finishB !== 1'b0) begin errors++; $display("[TB] FAIL t5_finish_early got=%0b exp=0", finishB); end
    dutCommit(32'd88, 32'h6f, 5'd0, 1'b0, 32'h0);
    checks++; if (finishB !== 1'b1 || stB !== ST_DRAIN) begin errors++; $display("[TB] FAIL t5_finish got fin=%0b st=%0d exp fin=1 st=%0d", finishB, stB, ST_DRAIN); end
    repeat (10) tick();
    checks++; if (passB !== 1'b0 || finishB !== 1'b1) begin errors++; $display("[TB] FAIL t5_hold got pass=%0b fin=%0b exp pass=0 fin=1", passB, finishB); end
    done_i = 1;
    tick();
    done_i = 0;
    checks++; if (passB !== 1'b1 || failB !== 1'b0 || finishB !== 1'b0) begin errors++; $display("[TB] FAIL t5_pass got pass=%0b fail=%0b fin=%0b exp 1/0/0", passB, failB, finishB); end
    dutCommit(32'h99, 32'h0, 5'd0, 1'b0, 32'h0);
    checks++; if (mmB !== 1'b0 || ccB !== 32'd2 || stB !== ST_PASS) begin errors++; $display("[TB] FAIL t5_terminal got mm=%0b cc=%0d st=%0d exp mm=0 cc=2 st=%0d", mmB, ccB, stB, ST_PASS); end
  endtask

  task test_end_fail();
    doReset();
    pushExp(32'h54, 32'h33, 5'd4, 1'b1, 32'h1);
    pushExp(32'd88, 32'h6f, 5'd0, 1'b0, 32'h0);
    startRun();
    dutCommit(32'h54, 32'h33, 5'd4, 1'b1, 32'h2);
    dutCommit(32'd88, 32'h6f, 5'd0, 1'b0, 32'h0);
    checks++; if (stB !== ST_DRAIN) begin errors++; $display("[TB] FAIL t5b_drain got=%0d exp=%0d", stB, ST_DRAIN); end
    repeat (10) tick();
    done_i = 1;
    tick();
    done_i = 0;
    checks++; if (failB !== 1'b1 || passB !== 1'b0 || mcB !== 32'd1) begin errors++; $display("[TB] FAIL t5b_fail got fail=%0b pass=%0b mc=%0d exp 1/0/1", failB, passB, mcB); end
  endtask

  task test_timeout();
    doReset();
    startRun();
    repeat (15) tick();
    checks++; if (stA !== ST_RUN || mmA !== 1'b0) begin errors++; $display("[TB] FAIL t6_before got st=%0d mm=%0b exp st=%0d mm=0", stA, mmA, ST_RUN); end
    tick();
    checks++; if (stA !== ST_FAIL || mmA !== 1'b1 || errA !== ERR_TIMEOUT) begin errors++; $display("[TB] FAIL t6_timeout got st=%0d mm=%0b err=%0d exp st=%0d mm=1 err=%0d", stA, mmA, errA, ST_FAIL, ERR_TIMEOUT); end
    checks++; if (cycA !== 32'd16 || mcA !== 32'd1) begin errors++; $display("[TB] FAIL t6_counts got cyc=%0d mc=%0d exp cyc=16 mc=1", cycA, mcA); end
  endtask

  task test_reset_in_drain();
    doReset();
    pushExp(32'd88, 32'h6f, 5'd1, 1'b1, 32'h7);
    startRun();
    dutCommit(32'd88, 32'h6f, 5'd1, 1'b1, 32'h8);
    dutCommit(32'h5, 32'h6, 5'd1, 1'b1, 32'h9);
    pushExp(32'd88, 32'h6f, 5'd1, 1'b1, 32'h7);
    dutCommit(32'd88, 32'h6f, 5'd1, 1'b1, 32'h7);
    checks++; if (stB !== ST_DRAIN) begin errors++; $display("[TB] FAIL t6b_drain got=%0d exp=%0d", stB, ST_DRAIN); end
    dut_valid_i = 1; dut_pc_i = 32'h77; done_i = 1;
    rst = 0;
    tick();
    dut_valid_i = 0; done_i = 0;
    checks++; if (stB !== ST_IDLE || readyB !== 1'b0 || {finishB, mmB, passB, failB} !== 4'b0) begin errors++; $display("[TB] FAIL t6b_reset_flags got st=%0d rdy=%0b flags=%b exp st=0 rdy=0 flags=0000", stB, readyB, {finishB, mmB, passB, failB}); end
    checks++; if (errB !== ERR_NONE || ccB !== 0 || mcB !== 0 || cycB !== 0) begin errors++; $display("[TB] FAIL t6b_reset_counters got err=%0d cc=%0d mc=%0d cyc=%0d exp all 0", errB, ccB, mcB, cycB); end
    rst = 1;
    tick();
  endtask

  initial begin
    test_reset();
    test_match();
    test_data_error();
    test_fifo_full();
    test_underflow();
    test_end_pass();
    test_end_fail();
    test_timeout();
    test_reset_in_drain();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
